// File: rtl/pgm_frame_sequencer.sv
// Frame sequencer: parses a PGM header (magic, width, height, maxval) and then streams
// width*height clamped pixels to the filter engine. Optional macro ROW_MARK_EN adds px_eol.
module pgm_frame_sequencer #(
  parameter logic [31:0] MAGIC   = 32'h0000_5032,
  parameter int          MAX_DIM = 4095
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  filter_type_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        px_valid,
  input  logic        px_ready,
  output logic [7:0]  px_data,
  output logic [1:0]  px_filter_type,
  output logic [11:0] frame_width,
  output logic [11:0] frame_height,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        sat_flag
`ifdef ROW_MARK_EN
  , output logic      px_eol
`endif
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    HDR_MAGIC = 4'd1,
    HDR_W     = 4'd2,
    HDR_H     = 4'd3,
    HDR_MAX   = 4'd4,
    STREAM    = 4'd5,
    DRAIN     = 4'd6,
    DONE      = 4'd7,
    ERROR     = 4'd8
  } state_t;

  localparam logic [31:0] MAX_DIM_W = 32'(MAX_DIM);

  state_t      state_r;
  logic [7:0]  maxval_r;
  logic [23:0] total_r;
  logic [23:0] count_r;
  logic        accept_s;
  logic        hdr_ok_s;
  logic        last_s;
  logic        over_s;
`ifdef ROW_MARK_EN
  logic [11:0] col_r;
  logic        eol_s;
`endif

  function automatic logic in_range(input logic [31:0] v, input logic [31:0] hi);
    in_range = (v >= 32'd1) && (v <= hi);
  endfunction

  // Upstream handshake: headers always accepted, pixels only when the output slot frees up
  always_comb begin
    in_ready = 1'b0;
    case (state_r)
      HDR_MAGIC, HDR_W, HDR_H, HDR_MAX: in_ready = 1'b1;
      STREAM:                           in_ready = !px_valid || px_ready;
      default:                          in_ready = 1'b0;
    endcase
  end

  // Header word validation for the current header state
  always_comb begin
    hdr_ok_s = 1'b0;
    case (state_r)
      HDR_MAGIC:    hdr_ok_s = (in_data == MAGIC);
      HDR_W, HDR_H: hdr_ok_s = in_range(in_data, MAX_DIM_W);
      HDR_MAX:      hdr_ok_s = in_range(in_data, 32'd255);
      default:      hdr_ok_s = 1'b0;
    endcase
  end

  assign accept_s = in_valid && in_ready;
  assign last_s   = (count_r == (total_r - 24'd1));
  assign over_s   = (in_data > {24'd0, maxval_r});
`ifdef ROW_MARK_EN
  assign eol_s    = (col_r == (frame_width - 12'd1));
`endif

  // Main sequencer FSM with registered status and pixel outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= IDLE;
      maxval_r       <= 8'd0;
      total_r        <= 24'd0;
      count_r        <= 24'd0;
      px_valid       <= 1'b0;
      px_data        <= 8'd0;
      px_filter_type <= 2'd0;
      frame_width    <= 12'd0;
      frame_height   <= 12'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      sat_flag       <= 1'b0;
`ifdef ROW_MARK_EN
      col_r          <= 12'd0;
      px_eol         <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE, ERROR: begin
          if (start) begin
            state_r        <= HDR_MAGIC;
            px_filter_type <= filter_type_in;
            error          <= 1'b0;
            sat_flag       <= 1'b0;
            count_r        <= 24'd0;
            frame_width    <= 12'd0;
            frame_height   <= 12'd0;
            busy           <= 1'b1;
`ifdef ROW_MARK_EN
            col_r          <= 12'd0;
            px_eol         <= 1'b0;
`endif
          end
        end
        HDR_MAGIC, HDR_W, HDR_H, HDR_MAX: begin
          if (accept_s) begin
            if (!hdr_ok_s) begin
              state_r <= ERROR;
              error   <= 1'b1;
              busy    <= 1'b0;
            end else begin
              case (state_r)
                HDR_MAGIC: state_r <= HDR_W;
                HDR_W: begin
                  frame_width <= in_data[11:0];
                  state_r     <= HDR_H;
                end
                HDR_H: begin
                  frame_height <= in_data[11:0];
                  state_r      <= HDR_MAX;
                end
                default: begin
                  maxval_r <= in_data[7:0];
                  total_r  <= {12'd0, frame_width} * {12'd0, frame_height};
                  state_r  <= STREAM;
                end
              endcase
            end
          end
        end
        STREAM: begin
          if (accept_s) begin
            px_valid <= 1'b1;
            px_data  <= over_s ? maxval_r : in_data[7:0];
            count_r  <= count_r + 24'd1;
            if (over_s) sat_flag <= 1'b1;
            if (last_s) state_r <= DRAIN;
`ifdef ROW_MARK_EN
            px_eol <= eol_s;
            col_r  <= eol_s ? 12'd0 : col_r + 12'd1;
`endif
          end else if (px_ready) begin
            px_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (px_ready) begin
            px_valid <= 1'b0;
            done     <= 1'b1;
            state_r  <= DONE;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r  <= ERROR;
          error    <= 1'b1;
          busy     <= 1'b0;
          px_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pgm_frame_sequencer.sv
// Directed self-checking bench for pgm_frame_sequencer (px_eol checked when ROW_MARK_EN is defined).
module tb_pgm_frame_sequencer;

  localparam logic [31:0] MAGIC = 32'h0000_5032;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  filter_type_in = 2'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic        px_valid;
  logic        px_ready = 1'b0;
  logic [7:0]  px_data;
  logic [1:0]  px_filter_type;
  logic [11:0] frame_width;
  logic [11:0] frame_height;
  logic        busy;
  logic        done;
  logic        error;
  logic        sat_flag;
`ifdef ROW_MARK_EN
  logic        px_eol;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pgm_frame_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .filter_type_in(filter_type_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data),
    .px_filter_type(px_filter_type), .frame_width(frame_width), .frame_height(frame_height),
    .busy(busy), .done(done), .error(error), .sat_flag(sat_flag)
`ifdef ROW_MARK_EN
    , .px_eol(px_eol)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_start(input logic [1:0] ft);
    filter_type_in = ft;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one word and hold it until accepted (bounded)
  task automatic push(input logic [31:0] w);
    int n;
    in_valid = 1'b1;
    in_data  = w;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (n == 20) check("push_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clock);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic header(input logic [31:0] w, input logic [31:0] h, input logic [31:0] m);
    push(MAGIC);
    push(w);
    push(h);
    push(m);
  endtask

  initial begin
    logic [7:0] pix [4];
    logic [3:0] pat;
    int  idx;
    int  beats;
    logic prev_stall;
    logic [7:0] prev_data;
    logic seen_done;

    // Reset state
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_px_valid", {31'd0, px_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_width", {20'd0, frame_width}, 32'd0);

    // 3x2 frame, px_ready always high
    do_start(2'b00);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_hdr_ready", {31'd0, in_ready}, 32'd1);
    px_ready = 1'b1;
    header(32'd3, 32'd2, 32'd255);
    check("t1_width", {20'd0, frame_width}, 32'd3);
    check("t1_height", {20'd0, frame_height}, 32'd2);
    for (int i = 0; i < 6; i++) begin
      check("t1_b2b_ready", {31'd0, in_ready}, 32'd1);
      push(32'((i + 1) * 10));
      check("t1_px_valid", {31'd0, px_valid}, 32'd1);
      check("t1_px_data", {24'd0, px_data}, 32'((i + 1) * 10));
`ifdef ROW_MARK_EN
      check("t1_px_eol", {31'd0, px_eol}, (i == 2 || i == 5) ? 32'd1 : 32'd0);
`endif
    end
    check("t1_drain_ready", {31'd0, in_ready}, 32'd0);
    check("t1_no_early_done", {31'd0, done}, 32'd0);
    tick();
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_done_pv", {31'd0, px_valid}, 32'd0);
    check("t1_done_busy", {31'd0, busy}, 32'd1);
    tick();
    check("t1_done_pulse", {31'd0, done}, 32'd0);
    check("t1_idle_busy", {31'd0, busy}, 32'd0);
    check("t1_sat", {31'd0, sat_flag}, 32'd0);
    check("t1_width_hold", {20'd0, frame_width}, 32'd3);

    // 1x1 frame, maxval 200, pixel 300 saturates; filter type latched at start
    do_start(2'b10);
    filter_type_in = 2'b01;
    header(32'd1, 32'd1, 32'd200);
    px_ready = 1'b0;
    push(32'd300);
    check("t2_px_data", {24'd0, px_data}, 32'd200);
    check("t2_sat", {31'd0, sat_flag}, 32'd1);
    check("t2_drain_ready", {31'd0, in_ready}, 32'd0);
    check("t2_ftype", {30'd0, px_filter_type}, 32'd2);
    tick();
    check("t2_stall_data", {24'd0, px_data}, 32'd200);
    check("t2_stall_valid", {31'd0, px_valid}, 32'd1);
    px_ready = 1'b1;
    tick();
    check("t2_done", {31'd0, done}, 32'd1);
    tick();
    check("t2_sat_hold", {31'd0, sat_flag}, 32'd1);
    check("t2_ftype_hold", {30'd0, px_filter_type}, 32'd2);

    // Bad magic then recovery
    do_start(2'b00);
    check("t3_sat_clear", {31'd0, sat_flag}, 32'd0);
    push(32'h0000_5035);
    check("t3_error", {31'd0, error}, 32'd1);
    check("t3_err_ready", {31'd0, in_ready}, 32'd0);
    check("t3_err_busy", {31'd0, busy}, 32'd0);
    tick();
    check("t3_error_hold", {31'd0, error}, 32'd1);
    do_start(2'b11);
    check("t3_error_clear", {31'd0, error}, 32'd0);
    header(32'd2, 32'd1, 32'd255);
    push(32'd5);
    check("t3_px0", {24'd0, px_data}, 32'd5);
    push(32'd7);
    check("t3_px1", {24'd0, px_data}, 32'd7);
    tick();
    check("t3_done", {31'd0, done}, 32'd1);
    tick();

    // Width 0 and height 4096 rejected
    do_start(2'b00);
    push(MAGIC);
    push(32'd0);
    check("t4_w0_error", {31'd0, error}, 32'd1);
    check("t4_w0_pv", {31'd0, px_valid}, 32'd0);
    do_start(2'b00);
    push(MAGIC);
    push(32'd5);
    push(32'd4096);
    check("t4_h4096_error", {31'd0, error}, 32'd1);
    check("t4_h4096_pv", {31'd0, px_valid}, 32'd0);

    // 2x2 frame with px_ready pattern 1,0,0,1
    do_start(2'b00);
    header(32'd2, 32'd2, 32'd255);
    pix[0] = 8'd11; pix[1] = 8'd22; pix[2] = 8'd33; pix[3] = 8'd44;
    pat = 4'b1001;
    idx = 0;
    beats = 0;
    prev_stall = 1'b0;
    prev_data = 8'd0;
    seen_done = 1'b0;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      px_ready = pat[c % 4];
      in_valid = (idx < 4);
      in_data  = (idx < 4) ? {24'd0, pix[idx]} : 32'd0;
      #1;
      if (prev_stall) check("t5_stable", {24'd0, px_data}, {24'd0, prev_data});
      if (px_valid && !px_ready) check("t5_stall_ready", {31'd0, in_ready}, 32'd0);
      if (px_valid && px_ready) begin
        check("t5_beat", {24'd0, px_data}, {24'd0, pix[beats]});
        beats++;
      end
      if (in_valid && in_ready) idx++;
      prev_stall = px_valid && !px_ready;
      prev_data  = px_data;
      tick();
      seen_done = done;
    end
    in_valid = 1'b0;
    check("t5_beats", 32'(beats), 32'd4);
    check("t5_done_seen", {31'd0, seen_done}, 32'd1);
    tick();

    // Reset mid-STREAM abandons the frame
    do_start(2'b10);
    filter_type_in = 2'b01;
    header(32'd2, 32'd2, 32'd255);
    px_ready = 1'b0;
    push(32'd9);
    check("t6_pv", {31'd0, px_valid}, 32'd1);
    check("t6_ftype", {30'd0, px_filter_type}, 32'd2);
    reset = 1'b1;
    tick();
    check("t6_rst_pv", {31'd0, px_valid}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_ftype", {30'd0, px_filter_type}, 32'd0);
    check("t6_rst_width", {20'd0, frame_width}, 32'd0);
    check("t6_rst_pxdata", {24'd0, px_data}, 32'd0);
    reset = 1'b0;
    tick();
    check("t6_no_done", {31'd0, done}, 32'd0);
    check("t6_idle_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
